mips_cp0_timer: RTL

Parametrised CP0 coprocessor for the pipelined MIPS CPU. It holds SR, Cause, EPC and EBase, and adds BadVAddr, Count and Compare registers. It has a configurable number of hardware interrupt lines and an internal Count/Compare timer interrupt. It sits beside the M stage: it takes exception/interrupt information from M, raises Req to the PC/flush logic, and serves mfc0/mtc0.

---
 rtl/mips_cp0_timer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mips_cp0_timer.sv
// mips_cp0_timer
//   CP0 for the pipelined MIPS core, sitting beside the M stage. Holds SR,
//   Cause, EPC, EBase, BadVAddr and the Count/Compare timer. Raises Req to
//   the PC/flush logic when an enabled interrupt or an exception is pending
//   and serves mfc0 (CP0Out) / mtc0 (en, CP0Add, CP0In).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   en, CP0Add, CP0In   mtc0 write strobe, register number, write data
//   CP0Out              mfc0 read data (combinational)
//   VPC, BDIn           victim PC and delay-slot flag from M
//   BadVAddrIn          faulting address from M
//   EXLClr              eret in M
//   ExcCodeIn           exception code from M (0 = none)
//   HWInt               level-sensitive external interrupt lines
//   Req                 enter-handler request (combinational)
//   EPCOut              EPC, bypassed with the new value while Req=1
//   EBase               handler base address
//   TimerIrq            Count/Compare interrupt bit (Cause.TI)
module mips_cp0_timer #(
    parameter int          NUM_HWINT   = 6,
    parameter bit          TIMER_EN    = 1'b1,
    parameter int          TIMER_LINE  = NUM_HWINT - 1,
    parameter logic [31:0] EBASE_RESET = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [4:0]           CP0Add,
    input  logic [31:0]          CP0In,
    output logic [31:0]          CP0Out,
    input  logic [31:0]          VPC,
    input  logic                 BDIn,
    input  logic [31:0]          BadVAddrIn,
    input  logic                 EXLClr,
    input  logic [4:0]           ExcCodeIn,
    input  logic [NUM_HWINT-1:0] HWInt,
    output logic                 Req,
    output logic [31:0]          EPCOut,
    output logic [31:0]          EBase,
    output logic                 TimerIrq
);

    logic [31:0]          sr_q, sr_d;
    logic                 bd_q, bd_d;
    logic                 ti_q, ti_d;
    logic [NUM_HWINT-1:0] ip_q;
    logic [4:0]           exccode_q, exccode_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          ebase_q, ebase_d;
    logic [31:0]          badvaddr_q, badvaddr_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;

    logic [NUM_HWINT-1:0] int_vec;
    logic                 int_req;
    logic                 exc_req;
    logic                 wr_en;
    logic [31:0]          epc_cand;
    logic [31:0]          cause_rd;

    always_comb begin
        int_vec             = HWInt;
        int_vec[TIMER_LINE] = HWInt[TIMER_LINE] | ti_q;
    end

    assign int_req  = ~sr_q[1] & sr_q[0] & (|(int_vec & sr_q[10 +: NUM_HWINT]));
    assign exc_req  = ~sr_q[1] & (ExcCodeIn != 5'd0);
    assign Req      = int_req | exc_req;
    // An mtc0 colliding with handler entry is squashed along with its instruction.
    assign wr_en    = en & ~Req;
    assign epc_cand = BDIn ? (VPC - 32'd4) : VPC;

    assign EPCOut   = Req ? epc_cand : epc_q;
    assign EBase    = ebase_q;
    assign TimerIrq = ti_q;

    always_comb begin
        cause_rd                   = '0;
        cause_rd[31]               = bd_q;
        cause_rd[30]               = ti_q;
        cause_rd[10 +: NUM_HWINT]  = ip_q;
        cause_rd[6:2]              = exccode_q;
    end

    always_comb begin
        case (CP0Add)
            5'd8:    CP0Out = badvaddr_q;
            5'd9:    CP0Out = TIMER_EN ? count_q : 32'd0;
            5'd11:   CP0Out = TIMER_EN ? compare_q : 32'd0;
            5'd12:   CP0Out = sr_q;
            5'd13:   CP0Out = cause_rd;
            5'd14:   CP0Out = epc_q;
            5'd15:   CP0Out = ebase_q;
            default: CP0Out = 32'd0;
        endcase
    end

    always_comb begin
        sr_d       = sr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        ebase_d    = ebase_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;

        if (EXLClr) begin
            sr_d[1] = 1'b0;
        end

        if (Req) begin
            sr_d[1]   = 1'b1;
            bd_d      = BDIn;
            epc_d     = epc_cand;
            exccode_d = int_req ? 5'd0 : ExcCodeIn;
            if (!int_req && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) begin
                badvaddr_d = BadVAddrIn;
            end
        end else if (en) begin
            case (CP0Add)
                5'd11:   compare_d = CP0In;
                5'd12:   sr_d      = CP0In;
                5'd14:   epc_d     = CP0In;
                5'd15:   ebase_d   = CP0In;
                default: ;
            endcase
        end

        count_d = (wr_en && CP0Add == 5'd9) ? CP0In : count_q + 32'd1;

        // Compare write acknowledges the timer; it beats a same-cycle match.
        if (wr_en && CP0Add == 5'd11) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end

        if (!TIMER_EN) begin
            count_d   = 32'd0;
            compare_d = 32'd0;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= 32'd0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            exccode_q  <= 5'd0;
            epc_q      <= 32'd0;
            ebase_q    <= EBASE_RESET;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
        end else begin
            sr_q       <= sr_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= int_vec;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            ebase_q    <= ebase_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
        end
    end

endmodule
